fb_pwm_encoder: RTL and testbench

Double-buffered frame buffer and PWM encoder that feeds the panel data pins alongside `display_driver`. It consumes the driver's `row`, `column`, `cycle` and `safe_flip` outputs and returns registered RGB data bits for both panel halves, two clocks after the address is presented. A host-side write port fills the back bank. Bank swaps happen only on `safe_flip`, so frames never tear.

---
 rtl/fb_pkg.sv | 36 +++
 rtl/fb_bank_ram.sv | 31 +++
 rtl/fb_pwm_encoder.sv | 223 ++++++++++++++++++++++
 tb/tb_fb_pwm_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the frame buffer / PWM encoder.
//   - pixel_t       : one 8-bit-per-channel pixel laid out as {r, g, b}
//   - swap_state_t  : bank swap controller states
//   - wr_addr_width : width of the host write address {segment, row, column}
//   - ram_addr_width: width of the per-segment linear pixel index
//   - gamma_value   : gamma 2.2 transfer curve; with max_code = 255 it
//                     produces the standard 8-bit gamma table
package fb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

  function automatic int wr_addr_width(int segments, int rows, int columns);
    return $clog2(segments) + $clog2(rows) + $clog2(columns);
  endfunction

  function automatic int ram_addr_width(int rows, int columns);
    return $clog2(rows * columns);
  endfunction

  // Evaluated at elaboration only (builds a constant ROM); int'() rounds.
  function automatic int gamma_value(int code, int max_code);
    real x;
    x = real'(code) / real'(max_code);
    return int'(real'(max_code) * (x ** 2.2));
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// fb_bank_ram: simple dual-port RAM, one write port and one registered read
// port on the same clock. Contents are not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : write data
//   rd_addr : read index, sampled every clock
//   rd_data : registered read data (one clock after rd_addr)
module fb_bank_ram #(
  parameter int width = 24,
  parameter int depth = 256,
  localparam int aw = $clog2(depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [aw-1:0]    wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic [aw-1:0]    rd_addr,
  output logic [width-1:0] rd_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fb_pwm_encoder.sv
// fb_pwm_encoder: double-buffered frame buffer with PWM bit encoding for the
// panel data pins. The front bank is read with the driver's {row, column}
// and compared against the driver's PWM cycle; the host fills the back bank.
// Banks swap only on safe_flip after a swap_req, so frames never tear.
//
// Optional build macro: FB_GAMMA_EN -- host pixels pass through a registered
// gamma 2.2 LUT before being stored (one extra write-pipe stage).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   row/column : read address from the driver
//   cycle      : PWM cycle from the driver
//   safe_flip  : single-cycle window in which a bank swap may happen
//   wr_valid/wr_ready/wr_addr/wr_data : host write port, addr {seg,row,col},
//                data {R,G,B}
//   swap_req   : request a swap at the next safe_flip
//   swap_done  : one-cycle pulse after the swap took effect
//   rgb        : {R,G,B} bit per segment, segment 0 in the LSBs, 2-clock latency
module fb_pwm_encoder
  import fb_pkg::*;
#(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int cycles   = 256,
  parameter int segments = 2,
  localparam int color_bits = $clog2(cycles),
  localparam int row_w      = $clog2(rows),
  localparam int col_w      = $clog2(columns),
  localparam int seg_w      = $clog2(segments),
  localparam int addr_w     = wr_addr_width(segments, rows, columns),
  localparam int pix_w      = 3 * color_bits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [row_w-1:0]        row,
  input  logic [col_w-1:0]        column,
  input  logic [color_bits-1:0]   cycle,
  input  logic                    safe_flip,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [addr_w-1:0]       wr_addr,
  input  logic [pix_w-1:0]        wr_data,
  input  logic                    swap_req,
  output logic                    swap_done,
  output logic [3*segments-1:0]   rgb
);

  localparam int depth = rows * columns;
  localparam int ram_w = ram_addr_width(rows, columns);
  localparam int cb    = color_bits;

  genvar gi;

  swap_state_t state_reg;
  logic        pending_reg;
  logic        disp_bank_reg;
  logic        wr_ready_reg;
  logic        swap_done_reg;

  // ---------------- host write address decode ----------------
  logic [seg_w-1:0] wa_seg;
  logic [row_w-1:0] wa_row;
  logic [col_w-1:0] wa_col;
  logic [ram_w-1:0] wa_idx;
  logic             wa_in_range;
  logic             wr_accept;

  assign {wa_seg, wa_row, wa_col} = wr_addr;
  assign wa_idx      = ram_w'(wa_row) * ram_w'(columns) + ram_w'(wa_col);
  assign wa_in_range = ({1'b0, wa_seg} < (seg_w + 1)'(segments)) &&
                       ({1'b0, wa_row} < (row_w + 1)'(rows)) &&
                       ({1'b0, wa_col} < (col_w + 1)'(columns));
  assign wr_accept   = wr_valid && wr_ready_reg;

  // Write port as seen by the RAMs, plus whether a bank toggle is safe now.
  logic             w_en;
  logic             w_bank;
  logic [seg_w-1:0] w_seg;
  logic [ram_w-1:0] w_idx;
  logic [pix_w-1:0] w_data;
  logic             flip_ok;

`ifdef FB_GAMMA_EN
  logic [cb-1:0]    gamma_lut [cycles];
  logic             wp_valid_reg;
  logic             wp_bank_reg;
  logic [seg_w-1:0] wp_seg_reg;
  logic [ram_w-1:0] wp_idx_reg;
  logic [pix_w-1:0] wp_data_reg;

  for (gi = 0; gi < cycles; gi++) begin : g_gamma
    assign gamma_lut[gi] = cb'(gamma_value(gi, cycles - 1));
  end

  // The target bank is captured at acceptance so a later toggle cannot
  // redirect this write into the displayed bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_valid_reg <= 1'b0;
    end else begin
      wp_valid_reg <= wr_accept && wa_in_range;
    end
    wp_bank_reg <= !disp_bank_reg;
    wp_seg_reg  <= wa_seg;
    wp_idx_reg  <= wa_idx;
    wp_data_reg <= {gamma_lut[wr_data[2*cb +: cb]],
                    gamma_lut[wr_data[cb +: cb]],
                    gamma_lut[wr_data[0 +: cb]]};
  end

  assign w_en    = wp_valid_reg && !rst;
  assign w_bank  = wp_bank_reg;
  assign w_seg   = wp_seg_reg;
  assign w_idx   = wp_idx_reg;
  assign w_data  = wp_data_reg;
  // Hold the toggle while anything is (or is entering) the write pipe.
  assign flip_ok = !wp_valid_reg && !wr_accept;
`else
  assign w_en    = wr_accept && wa_in_range && !rst;
  assign w_bank  = !disp_bank_reg;
  assign w_seg   = wa_seg;
  assign w_idx   = wa_idx;
  assign w_data  = wr_data;
  // Writes land in the same edge they are accepted, so nothing is in flight.
  assign flip_ok = 1'b1;
`endif

  // ---------------- swap controller ----------------
  logic flip;
  assign flip = safe_flip && flip_ok && (pending_reg || swap_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      disp_bank_reg <= 1'b0;
      wr_ready_reg  <= 1'b1;
      swap_done_reg <= 1'b0;
    end else begin
      swap_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (swap_req) begin
            if (flip) begin
              disp_bank_reg <= !disp_bank_reg;
              swap_done_reg <= 1'b1;
            end else begin
              state_reg    <= PENDING;
              pending_reg  <= 1'b1;
              wr_ready_reg <= 1'b0;
            end
          end
        end
        PENDING: begin
          if (flip) begin
            disp_bank_reg <= !disp_bank_reg;
            pending_reg   <= 1'b0;
            wr_ready_reg  <= 1'b1;
            swap_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------- bank RAMs (index = bank*segments + segment) ----------------
  logic [ram_w-1:0] rd_idx;
  logic [pix_w-1:0] ram_q [2*segments];

  assign rd_idx = ram_w'(row) * ram_w'(columns) + ram_w'(column);

  for (gi = 0; gi < 2 * segments; gi++) begin : g_ram
    localparam int bank_id = gi / segments;
    localparam int seg_id  = gi % segments;

    fb_bank_ram #(
      .width (pix_w),
      .depth (depth)
    ) u_ram (
      .clk     (clk),
      .wr_en   (w_en && (w_bank == 1'(bank_id)) && (w_seg == seg_w'(seg_id))),
      .wr_addr (w_idx),
      .wr_data (w_data),
      .rd_addr (rd_idx),
      .rd_data (ram_q[gi])
    );
  end

  // ---------------- read pipeline ----------------
  // Stage 1 is the RAM's registered read plus cycle/bank captured alongside;
  // stage 2 is the registered PWM compare.
  logic [cb-1:0]         cycle_d1_reg;
  logic                  bank_d1_reg;
  logic [3*segments-1:0] rgb_reg;
  logic [3*segments-1:0] rgb_next;

  for (gi = 0; gi < segments; gi++) begin : g_seg
    logic [pix_w-1:0] pix;
    assign pix = bank_d1_reg ? ram_q[segments + gi] : ram_q[gi];
    assign rgb_next[3*gi +: 3] = {pix[2*cb +: cb] > cycle_d1_reg,
                                  pix[cb +: cb]   > cycle_d1_reg,
                                  pix[0 +: cb]    > cycle_d1_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_d1_reg <= '0;
      bank_d1_reg  <= 1'b0;
      rgb_reg      <= '0;
    end else begin
      cycle_d1_reg <= cycle;
      bank_d1_reg  <= disp_bank_reg;
      rgb_reg      <= rgb_next;
    end
  end

  assign wr_ready  = wr_ready_reg;
  assign swap_done = swap_done_reg;
  assign rgb       = rgb_reg;

endmodule

// File: tb/tb_fb_pwm_encoder.sv
// Testbench for fb_pwm_encoder (default build). A behavioural model keeps
// both banks as plain arrays, the displayed bank and the pending flag, and
// predicts rgb / wr_ready / swap_done every clock from the input rules.
module tb_fb_pwm_encoder;
  import fb_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 32;
  localparam int CYC  = 256;
  localparam int SEGS = 2;
  localparam int NPIX = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] row;
  logic [4:0] column;
  logic [7:0] cycle;
  logic       safe_flip;
  logic       wr_valid;
  logic       wr_ready;
  logic [8:0] wr_addr;
  logic [23:0] wr_data;
  logic       swap_req;
  logic       swap_done;
  logic [5:0] rgb;

  always #5 clk = ~clk;

  fb_pwm_encoder #(
    .rows     (ROWS),
    .columns  (COLS),
    .cycles   (CYC),
    .segments (SEGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .column    (column),
    .cycle     (cycle),
    .safe_flip (safe_flip),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .rgb       (rgb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  pixel_t     mem   [2][SEGS][NPIX];
  bit         known [2][SEGS][NPIX];
  bit         m_bank;
  bit         m_pending;
  bit         exp_done;
  logic [5:0] s1_rgb, s1_mask;   // expected result of the read sampled last edge
  logic [5:0] e_rgb, e_mask;     // expected rgb now (mask 0 = undefined bits)

  // One clock: predict from the inputs as sampled at this edge, then check.
  task automatic step();
    int         idx, widx, wseg;
    bit         flip;
    pixel_t     p;
    logic [5:0] nb, nm;
    idx = int'(row) * COLS + int'(column);
    nb = '0;
    nm = '0;
    for (int s = 0; s < SEGS; s++) begin
      if (known[m_bank][s][idx] || int'(cycle) == CYC - 1) begin
        p = mem[m_bank][s][idx];
        nb[3*s+2] = int'(p.r) > int'(cycle);
        nb[3*s+1] = int'(p.g) > int'(cycle);
        nb[3*s]   = int'(p.b) > int'(cycle);
        nm[3*s +: 3] = 3'b111;
      end
    end
    @(posedge clk);
    if (rst) begin
      e_rgb     = '0;
      e_mask    = '1;
      s1_mask   = '0;
      m_bank    = 1'b0;
      m_pending = 1'b0;
      exp_done  = 1'b0;
    end else begin
      e_rgb   = s1_rgb;
      e_mask  = s1_mask;
      s1_rgb  = nb;
      s1_mask = nm;
      if (wr_valid && !m_pending) begin
        wseg = int'(wr_addr[8]);
        widx = int'(wr_addr[7:5]) * COLS + int'(wr_addr[4:0]);
        mem[!m_bank][wseg][widx]   = pixel_t'(wr_data);
        known[!m_bank][wseg][widx] = 1'b1;
      end
      flip = safe_flip && (m_pending || swap_req);
      if (flip) begin
        m_bank    = !m_bank;
        m_pending = 1'b0;
        $display("swap -> displayed bank %0d at %0t", m_bank, $time);
      end else if (swap_req) begin
        m_pending = 1'b1;
      end
      exp_done = flip;
    end
    #1;
    if (e_mask != 6'd0) check_eq("rgb", 32'(rgb & e_mask), 32'(e_rgb & e_mask));
    check_eq("wr_ready", 32'(wr_ready), 32'(!m_pending));
    check_eq("swap_done", 32'(swap_done), 32'(exp_done));
  endtask

  task automatic quiet_inputs();
    safe_flip = 1'b0;
    wr_valid  = 1'b0;
    swap_req  = 1'b0;
  endtask

  task automatic random_read();
    row    = 3'($urandom);
    column = 5'($urandom);
    cycle  = 8'($urandom);
  endtask

  // Write every pixel of the back bank, then swap with req+flip together.
  task automatic fill_and_swap();
    for (int i = 0; i < SEGS * NPIX; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 9'(i);
      wr_data  = 24'($urandom);
      random_read();
      step();
    end
    quiet_inputs();
    swap_req  = 1'b1;
    safe_flip = 1'b1;
    step();
    check_eq("imm_swap_done", 32'(swap_done), 32'd1);
    $display("bank filled and swapped in same cycle");
    quiet_inputs();
  endtask

  initial begin
    rst = 1'b1;
    row = '0; column = '0; cycle = '0;
    wr_addr = '0; wr_data = '0;
    quiet_inputs();
    m_bank = 1'b0; m_pending = 1'b0; exp_done = 1'b0;
    s1_rgb = '0; s1_mask = '0; e_rgb = '0; e_mask = '0;

    // Reset values, then reads at the last PWM cycle are dark for any address.
    repeat (3) step();
    check_eq("reset_rgb", 32'(rgb), 32'd0);
    check_eq("reset_ready", 32'(wr_ready), 32'd1);
    rst   = 1'b0;
    cycle = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      row    = 3'($urandom);
      column = 5'($urandom);
      step();
    end

    // R = 0x80 at seg0 row3 col5, swap on a later safe_flip.
    wr_valid = 1'b1;
    wr_addr  = {1'b0, 3'd3, 5'd5};
    wr_data  = 24'h800000;
    step();
    $display("write seg0 r3 c5 data 800000");
    quiet_inputs();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (3) step();
    safe_flip = 1'b1;
    step();
    check_eq("swap_done_pulse", 32'(swap_done), 32'd1);
    safe_flip = 1'b0;
    row = 3'd3; column = 5'd5; cycle = 8'h7F;
    step();
    check_eq("swap_done_clear", 32'(swap_done), 32'd0);
    cycle = 8'h80;
    step();
    check_eq("r_at_7f", 32'(rgb[2]), 32'd1);
    step();
    check_eq("r_at_80", 32'(rgb[2]), 32'd0);

    // Make both banks fully defined.
    fill_and_swap();
    fill_and_swap();

    // Extremes: seg0 {0,255,0}, seg1 {255,0,255} at row0 col0, swept over all cycles.
    wr_valid = 1'b1;
    wr_addr  = {1'b0, 3'd0, 5'd0};
    wr_data  = 24'h00FF00;
    step();
    wr_addr  = {1'b1, 3'd0, 5'd0};
    wr_data  = 24'hFF00FF;
    step();
    quiet_inputs();
    swap_req  = 1'b1;
    safe_flip = 1'b1;
    step();
    quiet_inputs();
    row = 3'd0; column = 5'd0;
    for (int c = 0; c < CYC; c++) begin
      cycle = 8'(c);
      step();
    end
    step();
    check_eq("sweep_255_at_255", 32'(rgb), 32'd0);

    // Random traffic: writes, reads, swap requests, flips.
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom % 3) == 0;
      wr_addr   = 9'($urandom);
      wr_data   = 24'($urandom);
      swap_req  = ($urandom % 40) == 0;
      safe_flip = ($urandom % 25) == 0;
      random_read();
      step();
    end
    quiet_inputs();
    safe_flip = 1'b1;   // drain any pending swap
    step();
    quiet_inputs();

    // Pending swap with no safe_flip for 1000 clocks: writes blocked, bank kept.
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr  = 9'($urandom);
      wr_data  = 24'($urandom);
      random_read();
      step();
    end
    check_eq("pending_ready_low", 32'(wr_ready), 32'd0);
    quiet_inputs();
    safe_flip = 1'b1;
    step();
    check_eq("late_swap_done", 32'(swap_done), 32'd1);
    quiet_inputs();

    // Reset while pending: no swap, bank 0 displayed afterwards.
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      safe_flip = ($urandom % 4) == 0;
      random_read();
      step();
    end
    quiet_inputs();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
